// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Purpose:
//   Tracks destination registers of instructions in flight after decode
//   (entry 0 = execute ... entry DEPTH-1 = writeback) and resolves RAW hazards
//   for the instruction in decode. The youngest in-flight writer of a source
//   register either forwards its result or, when the result is not yet
//   available, stalls decode and inserts a bubble.
//
// Build option:
//   HAZARD_BYPASS_EN  defined   -> forwarding from in-flight results enabled.
//                     undefined -> forwarding outputs tied to 0; any hazard
//                                  stalls until the writer leaves the pipeline.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_valid_i               decode holds an instruction
//   id_rs_i, id_rt_i         decode source registers
//   id_rs_used_i, id_rt_used_i  source actually read
//   id_rd_i, id_wen_i        decode destination register / write enable
//   adv_i                    pipeline advances this cycle
//   flush_i                  branch/jump redirect, kills youngest entries
//   stage_data_i             result of entry i at [i*XLEN +: XLEN]
//   stage_data_vld_i         bit i set when entry i's result is available
//   fwd_a_en_o, fwd_a_o      forwarded rs operand (combinational)
//   fwd_b_en_o, fwd_b_o      forwarded rt operand (combinational)
//   stall_o                  decode must hold (combinational)
//   stall_cnt_o              saturating count of advancing stall cycles
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 3,
    parameter int FLUSH_DEPTH = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid_i,
    input  logic [4:0]              id_rs_i,
    input  logic [4:0]              id_rt_i,
    input  logic                    id_rs_used_i,
    input  logic                    id_rt_used_i,
    input  logic [4:0]              id_rd_i,
    input  logic                    id_wen_i,
    input  logic                    adv_i,
    input  logic                    flush_i,
    input  logic [DEPTH*XLEN-1:0]   stage_data_i,
    input  logic [DEPTH-1:0]        stage_data_vld_i,
    output logic                    fwd_a_en_o,
    output logic                    fwd_b_en_o,
    output logic [XLEN-1:0]         fwd_a_o,
    output logic [XLEN-1:0]         fwd_b_o,
    output logic                    stall_o,
    output logic [31:0]             stall_cnt_o
);

`ifdef HAZARD_BYPASS_EN
    localparam logic BYPASS_EN = 1'b1;
`else
    localparam logic BYPASS_EN = 1'b0;
`endif

    logic [DEPTH-1:0]      vld_q, vld_d;
    logic [DEPTH-1:0]      wen_q, wen_d;
    logic [DEPTH-1:0][4:0] rd_q, rd_d;
    logic [31:0]           stall_cnt_q, stall_cnt_d;

    logic [DEPTH-1:0]      match_a_s, match_b_s;
    logic                  hit_a_s, hit_b_s, rdy_a_s, rdy_b_s;
    logic [XLEN-1:0]       data_a_s, data_b_s;
    logic                  haz_a_s, haz_b_s, stall_s;
    logic                  fwd_a_en_s, fwd_b_en_s, insert_s;

    // Find the youngest in-flight writer of each source register.
    always_comb begin
        hit_a_s  = 1'b0;
        hit_b_s  = 1'b0;
        rdy_a_s  = 1'b0;
        rdy_b_s  = 1'b0;
        data_a_s = '0;
        data_b_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_a_s[i] = vld_q[i] & wen_q[i] & (rd_q[i] != 5'd0) &
                           id_rs_used_i & (rd_q[i] == id_rs_i);
            match_b_s[i] = vld_q[i] & wen_q[i] & (rd_q[i] != 5'd0) &
                           id_rt_used_i & (rd_q[i] == id_rt_i);
        end
        // Walk oldest to youngest so the lowest index overwrites last.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            hit_a_s  = match_a_s[i] ? 1'b1 : hit_a_s;
            rdy_a_s  = match_a_s[i] ? stage_data_vld_i[i] : rdy_a_s;
            data_a_s = match_a_s[i] ? stage_data_i[i*XLEN +: XLEN] : data_a_s;
            hit_b_s  = match_b_s[i] ? 1'b1 : hit_b_s;
            rdy_b_s  = match_b_s[i] ? stage_data_vld_i[i] : rdy_b_s;
            data_b_s = match_b_s[i] ? stage_data_i[i*XLEN +: XLEN] : data_b_s;
        end
    end

    // Hazard, stall and forwarding decisions; all forced quiet while in reset.
    always_comb begin
        haz_a_s    = hit_a_s & (~rdy_a_s | ~BYPASS_EN);
        haz_b_s    = hit_b_s & (~rdy_b_s | ~BYPASS_EN);
        stall_s    = ~rst & id_valid_i & ~flush_i & (haz_a_s | haz_b_s);
        fwd_a_en_s = ~rst & BYPASS_EN & hit_a_s & rdy_a_s;
        fwd_b_en_s = ~rst & BYPASS_EN & hit_b_s & rdy_b_s;
        fwd_a_o    = fwd_a_en_s ? data_a_s : '0;
        fwd_b_o    = fwd_b_en_s ? data_b_s : '0;
        fwd_a_en_o = fwd_a_en_s;
        fwd_b_en_o = fwd_b_en_s;
        stall_o    = stall_s;
    end

    // Next state of the tracking shift register and the stall counter.
    always_comb begin
        vld_d    = vld_q;
        wen_d    = wen_q;
        rd_d     = rd_q;
        // Decode's instruction enters only when it is neither stalled nor flushed.
        insert_s = id_valid_i & ~stall_s & ~flush_i;
        if (adv_i) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                vld_d[i] = vld_q[i-1];
                wen_d[i] = wen_q[i-1];
                rd_d[i]  = rd_q[i-1];
            end
            vld_d[0] = insert_s;
            wen_d[0] = insert_s & id_wen_i;
            rd_d[0]  = insert_s ? id_rd_i : 5'd0;
        end else begin
            vld_d = vld_q;
        end
        // Flush acts after the shift/hold so it always hits the youngest slots.
        for (int i = 0; i < FLUSH_DEPTH; i++) begin
            vld_d[i] = flush_i ? 1'b0 : vld_d[i];
        end
        stall_cnt_d = (stall_s && adv_i && (stall_cnt_q != 32'hFFFF_FFFF)) ?
                      stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            wen_q       <= '0;
            rd_q        <= '0;
            stall_cnt_q <= 32'd0;
        end else begin
            vld_q       <= vld_d;
            wen_q       <= wen_d;
            rd_q        <= rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule
